// File: rtl/core_mc.sv
// Multicycle RV32I/RV32E core with one unified memory port using a ready/valid handshake.
// Sequence: FETCH -> DECODE -> EXECUTE -> (MEM -> WB) -> FETCH; traps and halts are terminal until reset.
module core_mc #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          NREGS            = 32,
    parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic        we,
    output logic [3:0]  wstrb,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic        halted,
    output logic        trap,
    output logic [31:0] trap_pc
);
    localparam int         AW      = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP, S_HALT
    } state_t;

    state_t state, state_next;

    logic [31:0] pc, instr, op_a, op_b, load_data;
    logic [1:0]  ea_lo;
    logic [31:0] regs [NREGS];

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic legal, uses_rd, uses_rs1, uses_rs2, reg_bad, decode_ok;

    always_comb begin
        legal    = 1'b0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                legal   = 1'b1;
                uses_rd = 1'b1;
            end
            OP_JALR: begin
                legal    = (funct3 == 3'b000);
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                legal    = (funct3 <= 3'b010);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                else
                    legal = 1'b1;
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_OP: begin
                legal    = (funct7 == 7'h00) ||
                           ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_FENCE:  legal = 1'b1;
            OP_SYSTEM: legal = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
            default:   legal = 1'b0;
        endcase
    end

    // Only fields the format actually uses are range-checked, so immediate bits never trap on RV32E.
    assign reg_bad = (uses_rd  && ({1'b0, rd}  >= NREGS_L)) ||
                     (uses_rs1 && ({1'b0, rs1} >= NREGS_L)) ||
                     (uses_rs2 && ({1'b0, rs2} >= NREGS_L));
    assign decode_ok = legal && !reg_bad;

    logic        is_op, is_load, is_store, is_jump, writes_rd, taken;
    logic [31:0] alu_b, alu_res, rd_val, target, target_fix, pc_plus4, pc_next;
    logic [31:0] ls_addr, ls_fix;
    logic [4:0]  shamt;
    logic signed [31:0] sra_res;
    logic        ls_bad, target_bad, exec_trap;

    assign is_op     = (opcode == OP_OP);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign writes_rd = is_op || (opcode == OP_IMM) || (opcode == OP_LUI) ||
                       (opcode == OP_AUIPC) || is_jump;
    assign alu_b     = is_op ? op_b : imm_i;
    assign shamt     = alu_b[4:0];
    assign sra_res   = $signed(op_a) >>> shamt;
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = (is_op && funct7[5]) ? op_a - alu_b : op_a + alu_b;
            3'b001: alu_res = op_a << shamt;
            3'b010: alu_res = {31'b0, $signed(op_a) < $signed(alu_b)};
            3'b011: alu_res = {31'b0, op_a < alu_b};
            3'b100: alu_res = op_a ^ alu_b;
            3'b101: alu_res = funct7[5] ? sra_res : op_a >> shamt;
            3'b110: alu_res = op_a | alu_b;
            3'b111: alu_res = op_a & alu_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000: taken = (op_a == op_b);
            3'b001: taken = (op_a != op_b);
            3'b100: taken = ($signed(op_a) < $signed(op_b));
            3'b101: taken = !($signed(op_a) < $signed(op_b));
            3'b110: taken = (op_a < op_b);
            3'b111: taken = !(op_a < op_b);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        rd_val = alu_res;
        target = pc + imm_b;
        case (opcode)
            OP_LUI:   rd_val = imm_u;
            OP_AUIPC: rd_val = pc + imm_u;
            OP_JAL: begin
                rd_val = pc_plus4;
                target = pc + imm_j;
            end
            OP_JALR: begin
                rd_val = pc_plus4;
                target = (op_a + imm_i) & ~32'h1;
            end
            default: rd_val = alu_res;
        endcase
    end

    // A misaligned target either traps or is rounded down to a word boundary.
    assign target_fix = {target[31:2], 2'b00};
    assign target_bad = (is_jump || ((opcode == OP_BRANCH) && taken)) && target[1];
    assign pc_next    = (is_jump || ((opcode == OP_BRANCH) && taken)) ? target_fix : pc_plus4;

    assign ls_addr = op_a + (is_store ? imm_s : imm_i);
    assign ls_bad  = ((funct3[1:0] == 2'b01) && ls_addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
    assign ls_fix  = (funct3[1:0] == 2'b01) ? {ls_addr[31:1], 1'b0} :
                     (funct3[1:0] == 2'b10) ? {ls_addr[31:2], 2'b00} : ls_addr;
    assign exec_trap = TRAP_ON_MISALIGN && (target_bad || ((is_load || is_store) && ls_bad));

    logic [3:0]  st_strb;
    logic [31:0] st_data, ld_shift, ld_val;

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << ls_fix[1:0];
                st_data = {4{op_b[7:0]}};
            end
            2'b01: begin
                st_strb = ls_fix[1] ? 4'b1100 : 4'b0011;
                st_data = {2{op_b[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = op_b;
            end
        endcase
    end

    assign ld_shift = load_data >> {ea_lo, 3'b000};

    always_comb begin
        case (funct3)
            3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_val = {24'b0, ld_shift[7:0]};
            3'b101:  ld_val = {16'b0, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:   if (mem_req && mem_ready) state_next = S_DECODE;
            S_DECODE:  state_next = decode_ok ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                if (exec_trap)
                    state_next = S_TRAP;
                else if (opcode == OP_SYSTEM)
                    state_next = S_HALT;
                else if (is_load || is_store)
                    state_next = S_MEM;
                else
                    state_next = S_FETCH;
            end
            S_MEM:     if (mem_req && mem_ready) state_next = we ? S_FETCH : S_WB;
            S_WB:      state_next = S_FETCH;
            default:   state_next = state;
        endcase
    end

    // Bus outputs are registered, so each request is raised on the edge that enters FETCH or MEM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            instr     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            load_data <= '0;
            ea_lo     <= '0;
            address   <= '0;
            data_out  <= '0;
            we        <= 1'b0;
            wstrb     <= '0;
            mem_req   <= 1'b0;
            halted    <= 1'b0;
            trap      <= 1'b0;
            trap_pc   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                        address <= pc;
                        we      <= 1'b0;
                        wstrb   <= '0;
                    end else if (mem_ready) begin
                        instr   <= data_in;
                        mem_req <= 1'b0;
                    end
                end
                S_DECODE: begin
                    op_a <= regs[rs1[AW-1:0]];
                    op_b <= regs[rs2[AW-1:0]];
                    if (!decode_ok) begin
                        trap    <= 1'b1;
                        trap_pc <= pc;
                    end
                end
                S_EXECUTE: begin
                    if (exec_trap) begin
                        trap    <= 1'b1;
                        trap_pc <= pc;
                    end else if (opcode == OP_SYSTEM) begin
                        halted  <= 1'b1;
                        trap_pc <= pc;
                    end else if (is_load || is_store) begin
                        ea_lo    <= ls_fix[1:0];
                        mem_req  <= 1'b1;
                        address  <= {ls_fix[31:2], 2'b00};
                        we       <= is_store;
                        wstrb    <= is_store ? st_strb : 4'b0000;
                        data_out <= st_data;
                    end else begin
                        if (writes_rd && (rd != 5'd0)) regs[rd[AW-1:0]] <= rd_val;
                        pc      <= pc_next;
                        mem_req <= 1'b1;
                        address <= pc_next;
                        we      <= 1'b0;
                        wstrb   <= '0;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (we) begin
                            pc      <= pc_plus4;
                            address <= pc_plus4;
                            we      <= 1'b0;
                            wstrb   <= '0;
                        end else begin
                            load_data <= data_in;
                            mem_req   <= 1'b0;
                        end
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) regs[rd[AW-1:0]] <= ld_val;
                    pc      <= pc_plus4;
                    mem_req <= 1'b1;
                    address <= pc_plus4;
                    we      <= 1'b0;
                    wstrb   <= '0;
                end
                default: mem_req <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_core_mc.sv
// Bench for core_mc: hand-assembled programs, expected bus transactions queued up front,
// and a memory-side monitor that pops and checks each handshake as the core issues it.
module tb_core_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address, data_out, data_in, trap_pc;
    logic        we, mem_req, halted, trap;
    logic [3:0]  wstrb;
    logic        mem_ready = 1'b1;

    logic [31:0] mem [0:2047];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cyc = -1;
    int wait_cfg = 0;
    int wait_cnt = 0;
    bit pend = 1'b0;
    logic [31:0] held_addr, held_data;
    logic        held_we;
    logic [3:0]  held_strb;

    core_mc #(
        .RESET_PC(32'h0000_0100),
        .NREGS(16),
        .TRAP_ON_MISALIGN(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .data_out(data_out),
        .data_in(data_in),
        .we(we),
        .wstrb(wstrb),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .halted(halted),
        .trap(trap),
        .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data_in = mem[address[12:2]];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder and monitor: inserts wait_cfg wait states per request and checks every handshake.
    always @(negedge clk) begin
        if (reset) begin
            last_cyc  = -1;
            pend      = 1'b0;
            wait_cnt  = 0;
            mem_ready = (wait_cfg == 0);
        end else begin
            if (pend) begin
                check_output("req_held", {31'b0, mem_req}, 32'd1);
                check_output("addr_stable", address, held_addr);
                check_output("ctl_stable", {27'b0, we, wstrb}, {27'b0, held_we, held_strb});
                check_output("wdata_stable", data_out, held_data);
            end
            if (!mem_req) begin
                wait_cnt  = 0;
                pend      = 1'b0;
                mem_ready = (wait_cfg == 0);
            end else if (wait_cnt < wait_cfg) begin
                wait_cnt++;
                mem_ready = 1'b0;
                pend      = 1'b1;
                held_addr = address;
                held_data = data_out;
                held_we   = we;
                held_strb = wstrb;
            end else begin
                exp_t e;
                mem_ready = 1'b1;
                wait_cnt  = 0;
                pend      = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_req: got addr 0x%08h we %0b, expected no request", address, we);
                end else begin
                    e = exp_q.pop_front();
                    check_output("bus_addr", address, e.addr);
                    check_output("bus_we", {31'b0, we}, {31'b0, e.we});
                    check_output("bus_wstrb", {28'b0, wstrb}, {28'b0, e.wstrb});
                    if (e.we) check_output("bus_wdata", data_out, e.data);
                    if (e.gap >= 0 && last_cyc >= 0) check_output("bus_gap", cyc - last_cyc, e.gap);
                end
                if (we) begin
                    for (int i = 0; i < 4; i++)
                        if (wstrb[i]) mem[address[12:2]][8*i +: 8] = data_out[8*i +: 8];
                end
                last_cyc = cyc;
            end
        end
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd);
        return {imm20[19:0], rd[4:0], 7'b0110111};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[12:2]] = word;
    endtask

    task automatic exp_bus(input logic [31:0] addr, input logic w, input logic [3:0] strb,
                           input logic [31:0] data, input int gap);
        exp_t e;
        e.addr  = addr;
        e.we    = w;
        e.wstrb = strb;
        e.data  = data;
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    task automatic exp_rd(input logic [31:0] addr, input int gap);
        exp_bus(addr, 1'b0, 4'b0000, 32'h0, gap);
    endtask

    // Holds the core in reset, checks the reset outputs and clears memory for the next program.
    task automatic start_test(input string name);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        @(negedge clk);
        check_output({name, "_rst_req"}, {31'b0, mem_req}, 32'd0);
        check_output({name, "_rst_addr"}, address, 32'h0);
        check_output({name, "_rst_wdata"}, data_out, 32'h0);
        check_output({name, "_rst_ctl"}, {27'b0, we, wstrb}, 32'h0);
        check_output({name, "_rst_flags"}, {30'b0, halted, trap}, 32'h0);
        check_output({name, "_rst_trap_pc"}, trap_pc, 32'h0);
    endtask

    task automatic run_test(input string name, input int waits, input bit expect_halt,
                            input logic [31:0] expect_pc);
        int n;
        wait_cfg = waits;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!(halted || trap) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(halted || trap)) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got no halt or trap, expected one within 3000 cycles", name);
        end
        repeat (6) @(negedge clk);
        check_output({name, "_halted"}, {31'b0, halted}, {31'b0, expect_halt});
        check_output({name, "_trap"}, {31'b0, trap}, {31'b0, !expect_halt});
        check_output({name, "_trap_pc"}, trap_pc, expect_pc);
        check_output({name, "_req_idle"}, {31'b0, mem_req}, 32'd0);
        check_output({name, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        // ALU sequence: 3 cycles per instruction, results observed through stores.
        start_test("alu");
        put(32'h100, enc_i(5, 0, 0, 1, 7'b0010011));
        put(32'h104, enc_i(-7, 1, 0, 2, 7'b0010011));
        put(32'h108, enc_r(0, 2, 1, 3, 3));
        put(32'h10C, enc_s(32'h400, 2, 0, 2));
        put(32'h110, enc_s(32'h404, 3, 0, 2));
        put(32'h114, enc_r(32'h20, 2, 1, 0, 6));
        put(32'h118, enc_s(32'h408, 6, 0, 2));
        put(32'h11C, 32'h0000_0073);
        exp_rd(32'h100, -1);
        exp_rd(32'h104, 3);
        exp_rd(32'h108, 3);
        exp_rd(32'h10C, 3);
        exp_bus(32'h400, 1'b1, 4'b1111, 32'hFFFF_FFFE, 3);
        exp_rd(32'h110, 1);
        exp_bus(32'h404, 1'b1, 4'b1111, 32'h0000_0001, 3);
        exp_rd(32'h114, 1);
        exp_rd(32'h118, 3);
        exp_bus(32'h408, 1'b1, 4'b1111, 32'h0000_0007, 3);
        exp_rd(32'h11C, 1);
        run_test("alu", 0, 1'b1, 32'h11C);

        // Sub-word loads and stores with lane strobes and sign/zero extension.
        start_test("bytes");
        put(32'h1000, 32'h80FF_7F01);
        put(32'h100, enc_u(1, 1));
        put(32'h104, enc_u(32'hAABBD, 2));
        put(32'h108, enc_i(-803, 2, 0, 2, 7'b0010011));
        put(32'h10C, enc_i(3, 1, 0, 4, 7'b0000011));
        put(32'h110, enc_i(0, 1, 5, 5, 7'b0000011));
        put(32'h114, enc_s(3, 2, 1, 0));
        put(32'h118, enc_s(4, 4, 1, 2));
        put(32'h11C, enc_s(8, 5, 1, 2));
        put(32'h120, enc_s(2, 2, 1, 1));
        put(32'h124, 32'h0010_0073);
        exp_rd(32'h100, -1);
        exp_rd(32'h104, 3);
        exp_rd(32'h108, 3);
        exp_rd(32'h10C, 3);
        exp_rd(32'h1000, 3);
        exp_rd(32'h110, 2);
        exp_rd(32'h1000, 3);
        exp_rd(32'h114, 2);
        exp_bus(32'h1000, 1'b1, 4'b1000, 32'hDDDD_DDDD, 3);
        exp_rd(32'h118, 1);
        exp_bus(32'h1004, 1'b1, 4'b1111, 32'hFFFF_FF80, 3);
        exp_rd(32'h11C, 1);
        exp_bus(32'h1008, 1'b1, 4'b1111, 32'h0000_7F01, 3);
        exp_rd(32'h120, 1);
        exp_bus(32'h1000, 1'b1, 4'b1100, 32'hCCDD_CCDD, 3);
        exp_rd(32'h124, 1);
        run_test("bytes", 0, 1'b1, 32'h124);

        // Three wait states on every request; bus must hold steady while stalled.
        start_test("wait");
        put(32'h1000, 32'h1234_5678);
        put(32'h100, enc_u(1, 1));
        put(32'h104, enc_i(0, 1, 2, 4, 7'b0000011));
        put(32'h108, enc_s(4, 4, 1, 2));
        put(32'h10C, 32'h0000_0073);
        exp_rd(32'h100, -1);
        exp_rd(32'h104, 6);
        exp_rd(32'h1000, 6);
        exp_rd(32'h108, 5);
        exp_bus(32'h1004, 1'b1, 4'b1111, 32'h1234_5678, 6);
        exp_rd(32'h10C, 4);
        run_test("wait", 3, 1'b1, 32'h10C);

        // Control flow: jal, taken beq, jalr with bit0 cleared, not-taken bne.
        start_test("branch");
        put(32'h100, enc_j(-32'hE0, 0));
        put(32'h020, enc_b(8, 0, 0, 0));
        put(32'h028, enc_i(32'h31, 0, 0, 1, 7'b1100111));
        put(32'h030, enc_b(8, 0, 0, 1));
        put(32'h034, enc_s(32'h400, 1, 0, 2));
        put(32'h038, 32'h0000_0073);
        exp_rd(32'h100, -1);
        exp_rd(32'h020, 3);
        exp_rd(32'h028, 3);
        exp_rd(32'h030, 3);
        exp_rd(32'h034, 3);
        exp_bus(32'h400, 1'b1, 4'b1111, 32'h0000_002C, 3);
        exp_rd(32'h038, 1);
        run_test("branch", 0, 1'b1, 32'h038);

        // Misaligned word load traps before any data request.
        start_test("misld");
        put(32'h100, enc_u(1, 1));
        put(32'h104, enc_i(2, 1, 2, 2, 7'b0000011));
        exp_rd(32'h100, -1);
        exp_rd(32'h104, 3);
        run_test("misld", 0, 1'b0, 32'h104);

        // x20 does not exist on the 16-register configuration.
        start_test("rv32e");
        put(32'h100, enc_r(0, 0, 0, 0, 20));
        exp_rd(32'h100, -1);
        run_test("rv32e", 0, 1'b0, 32'h100);

        // Jump target with bit1 set traps.
        start_test("misjmp");
        put(32'h100, enc_i(32'h32, 0, 0, 1, 7'b1100111));
        exp_rd(32'h100, -1);
        run_test("misjmp", 0, 1'b0, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_mc.md
Name: core_mc

Overview:
- Parametrised multicycle RV32I core, the next generation of the team's single-memory-port core.
- Adds a ready/valid memory handshake with wait states, byte/halfword loads and stores with byte strobes, and a configurable register count (RV32I or RV32E).
- Adds a configurable reset vector, plus trap and halt reporting.
- Sits between the top-level and the unified instruction/data memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NREGS, 32, architectural register count; legal values 32 (RV32I) or 16 (RV32E).
TRAP_ON_MISALIGN, 1, 1 = misaligned load/store/jump target traps; 0 = low address bits are forced to alignment and execution continues.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
address  output  32  memory byte address.
data_out  output  32  store data, lane-aligned to address[1:0].
data_in  input  32  memory read data; valid when mem_ready=1.
we  output  1  write enable; meaningful only while mem_req=1.
wstrb  output  4  byte-lane strobes for stores; 4'b0000 on reads.
mem_req  output  1  request valid; held with stable address, data_out, we and wstrb until mem_ready.
mem_ready  input  1  request completes in any cycle where mem_req=1 and mem_ready=1.
halted  output  1  sticky; set by ECALL/EBREAK.
trap  output  1  sticky; set by an illegal instruction or a misaligned access.
trap_pc  output  32  PC of the instruction that halted or trapped.

Behaviour:
- Reset (async assert): pc=RESET_PC; state=FETCH; mem_req=0; we=0; wstrb=0; address=0; data_out=0; halted=0; trap=0; trap_pc=0; all registers 0. On the first edge after deassert, the FSM issues a fetch.
- x0 reads 0 always; writes to x0 are discarded.
- States:
  - FETCH: mem_req=1, address=pc, we=0. Wait while mem_ready=0. On handshake, latch instr=data_in and go to DECODE.
  - DECODE: read rs1/rs2 into operand registers; decode opcode; go to EXECUTE. Illegal encoding, or any rd/rs1/rs2 >= NREGS, goes to TRAP.
  - EXECUTE: ALU/branch compare.
    - OP/OP-IMM/LUI/AUIPC: write rd; pc+=4; go to FETCH.
    - JAL/JALR: rd=pc+4; pc=target (JALR clears bit0); go to FETCH.
    - BRANCH: pc = taken ? pc+immB : pc+4; go to FETCH.
    - LOAD/STORE: latch effective address rs1+imm; go to MEM.
    - ECALL/EBREAK: go to HALT.
  - MEM: mem_req=1, address = effective address with bits[1:0] cleared.
    - Store: we=1; wstrb per SB/SH/SW and addr[1:0]; data replicated into the lanes.
    - On handshake: load goes to WB, store does pc+=4 and goes to FETCH.
  - WB: extract byte/half from data_in per addr[1:0] (data latched at handshake); sign-extend LB/LH, zero-extend LBU/LHU; write rd; pc+=4; go to FETCH.
  - TRAP / HALT: set trap or halted and trap_pc=pc; mem_req=0. Terminal until reset.
- Latency with mem_ready tied 1: ALU/branch/jump 3 cycles; store 4; load 5. Each wait cycle adds 1.
- Misalignment (TRAP_ON_MISALIGN=1):
  - LH/LHU/SH with addr[0]=1 traps.
  - LW/SW with addr[1:0]!=0 traps.
  - A taken branch/jump target with bit1=1 traps.
  - Detection occurs in EXECUTE, no memory request is issued, and the rd write is suppressed.
- Shifts use operand[4:0]. SLT/SLTU are signed/unsigned. All arithmetic is mod 2^32. FENCE executes as a NOP.
- mem_ready asserted while mem_req=0 is ignored.
- Reset asserted mid-request drops mem_req immediately (async); no write completes after reset asserts.

Test Plan:
- Reset with RESET_PC=32'h100, mem_ready=1 → first request address=0x100, we=0; outputs 0 during reset.
- addi x1,x0,5; addi x2,x1,-7; sltu x3,x1,x2 → x2=0xFFFFFFFE, x3=1; each instruction takes 3 cycles.
- x1=0x1000, x2=0xAABBCCDD; sb x2,3(x1) → address=0x1000, wstrb=4'b1000, data_out[31:24]=0xDD. Memory word 0x80FF7F01 at 0x1000; lb x4,3(x1) → x4=0xFFFFFF80; lhu x5,0(x1) → x5=0x00007F01.
- mem_ready low for 3 cycles during fetch and load → address/mem_req stable throughout; load completes in 8 cycles; result unchanged.
- beq x0,x0,+8 at 0x20 → next fetch at 0x28. jalr x1,x0,0x31 → x1=pc+4, next fetch at 0x30.
- lw from 0x1002 → trap=1, trap_pc=address of the lw, no memory request. add x20,x0,x0 with NREGS=16 → trap=1. ecall → halted=1, mem_req stays 0.
